mem_unit: RTL and testbench

- Single-port synchronous RAM: write-enable/read-enable, one shared address bus, separate write-data and read-data buses.
- Generic scratch/data store for the RISC-V datapath and its benches.
- Depth is 2**MEMSIZE words of WORDSIZE bits.
- Registered read output with a valid strobe.

---
 rtl/mem_unit_pkg.sv | 7 +
 rtl/mem_unit_clear_seq.sv | 55 +++++
 rtl/mem_unit.sv | 78 +++++++
 tb/tb_mem_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mem_unit_pkg.sv
// Shared constants and sequencer state encoding for the mem_unit scratch RAM.
package mem_unit_pkg;
  localparam int MEMSIZE_DEF  = 16;
  localparam int WORDSIZE_DEF = 4;

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} clr_state_e;
endpackage

// File: rtl/mem_unit_clear_seq.sv
// Post-reset zero-fill sequencer: sweeps every address once, holding busy while it runs.
module mem_unit_clear_seq
  import mem_unit_pkg::*;
#(
  parameter int MEMSIZE = MEMSIZE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               clear_we,
  output logic [MEMSIZE-1:0] clear_addr,
  output logic               busy
);
  clr_state_e         state_q, state_d;
  logic               pend_q, pend_d;
  logic [MEMSIZE-1:0] caddr_q, caddr_d;

  // pend_q keeps busy low during reset itself; the sweep starts on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b1;
      caddr_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      caddr_q <= caddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    caddr_d = caddr_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_CLEAR;
          pend_d  = 1'b0;
          caddr_d = '0;
        end
      end
      ST_CLEAR: begin
        caddr_d = caddr_q + MEMSIZE'(1);
        if (&caddr_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == ST_CLEAR);
    clear_we   = busy;
    clear_addr = caddr_q;
  end
endmodule

// File: rtl/mem_unit.sv
// Single-port synchronous RAM with registered read data and a read-valid strobe.
// Optional post-reset zero-fill sweep is enabled with `define MEM_UNIT_CLEAR_EN.
module mem_unit
  import mem_unit_pkg::*;
#(
  parameter int MEMSIZE  = MEMSIZE_DEF,
  parameter int WORDSIZE = WORDSIZE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wren,
  input  logic                rden,
  input  logic [MEMSIZE-1:0]  addr,
  input  logic [WORDSIZE-1:0] d,
  output logic [WORDSIZE-1:0] q,
  output logic                q_valid,
  output logic                busy
);
  logic [WORDSIZE-1:0] mem [0:(1<<MEMSIZE)-1];

  logic                clear_we;
  logic [MEMSIZE-1:0]  clear_addr;
  logic                we;
  logic [MEMSIZE-1:0]  wa;
  logic [WORDSIZE-1:0] wd;
  logic                rd_en;
  logic [WORDSIZE-1:0] rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

`ifdef MEM_UNIT_CLEAR_EN
  mem_unit_clear_seq #(.MEMSIZE(MEMSIZE)) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .busy       (busy)
  );
`else
  assign clear_we   = 1'b0;
  assign clear_addr = '0;
  assign busy       = 1'b0;
`endif

  // sweep owns the write port while busy; user accesses are dropped
  always_comb begin
    we    = clear_we | (wren & ~busy);
    wa    = clear_we ? clear_addr : addr;
    wd    = clear_we ? '0 : d;
    rd_en = rden & ~busy;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // read and write share one address, so a concurrent write always forwards d
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = wren ? d : mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign q       = rdata_q;
  assign q_valid = rvalid_q;
endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit; shrinks the array and checks the sweep when MEM_UNIT_CLEAR_EN is set.
module tb_mem_unit;
`ifdef MEM_UNIT_CLEAR_EN
  localparam int MS = 4;
`else
  localparam int MS = 16;
`endif
  localparam int WS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wren = 1'b0, rden = 1'b0;
  logic [MS-1:0] addr = '0;
  logic [WS-1:0] d = '0;
  logic [WS-1:0] q;
  logic          q_valid, busy;

  int total = 0;
  int bad   = 0;

  mem_unit #(.MEMSIZE(MS), .WORDSIZE(WS)) dut (
    .clk(clk), .rst_n(rst_n), .wren(wren), .rden(rden),
    .addr(addr), .d(d), .q(q), .q_valid(q_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge and settle outputs
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [MS-1:0] a, input logic [WS-1:0] v);
    addr = a; d = v; wren = 1'b1; rden = 1'b0;
    step();
    wren = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [MS-1:0] a, input logic [WS-1:0] exp);
    addr = a; rden = 1'b1; wren = 1'b0;
    step();
    chk(tag, {28'd0, q}, {28'd0, exp});
    chk({tag, "_v"}, {31'd0, q_valid}, 32'd1);
    rden = 1'b0;
  endtask

  // counts busy cycles after reset release; bound keeps the run finite
  task automatic wait_idle(output int cycles);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      cycles++;
      step();
    end
    chk("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    logic [MS-1:0] ones;
    ones = '1;

    #12;
    chk("rst_q", {28'd0, q}, 32'd0);
    chk("rst_qv", {31'd0, q_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step();

`ifdef MEM_UNIT_CLEAR_EN
    // user writes and reads during the sweep must be ignored
    wren = 1'b1; rden = 1'b1; addr = 4'd7; d = 4'hF;
    n = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      if (q_valid) chk("busy_qv", {31'd0, q_valid}, 32'd0);
      n++;
      step();
    end
    wren = 1'b0; rden = 1'b0;
    chk("sweep_len", n, 32'd16);
    for (int i = 0; i < 16; i++) rd("clr_rd", MS'(i), 4'h0);
`else
    wait_idle(n);
    chk("no_busy", n, 32'd0);
`endif

    for (int i = 0; i < 16; i++) wr(MS'(i), WS'(15 - i));
    for (int i = 0; i < 16; i++) rd("rev_rd", MS'(15 - i), WS'(i));

    rden = 1'b0; addr = MS'(5);
    step();
    chk("hold_q", {28'd0, q}, 32'd15);
    chk("hold_qv", {31'd0, q_valid}, 32'd0);
    step();
    chk("hold_q2", {28'd0, q}, 32'd15);
    rd("hold_mem5", MS'(5), 4'd10);

    addr = MS'(3); d = 4'd9; wren = 1'b1; rden = 1'b1;
    step();
    wren = 1'b0; rden = 1'b0;
    chk("wt_q", {28'd0, q}, 32'd9);
    chk("wt_qv", {31'd0, q_valid}, 32'd1);
    rd("wt_later", MS'(3), 4'd9);

    rd("pre_rst", MS'(8), 4'd7);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_q", {28'd0, q}, 32'd0);
    chk("arst_qv", {31'd0, q_valid}, 32'd0);
    #1 rst_n = 1'b1;
    step();
`ifdef MEM_UNIT_CLEAR_EN
    wait_idle(n);
    chk("resweep_len", n, 32'd16);
    rd("resweep_mem8", MS'(8), 4'h0);
`else
    rd("keep_mem8", MS'(8), 4'd7);
    rd("keep_mem3", MS'(3), 4'd9);
`endif

    wr(ones, 4'hA);
    wr('0, 4'h5);
    rd("bnd_hi", ones, 4'hA);
    rd("bnd_lo", '0, 4'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
